sad_disparity_search: RTL

SAD_DISPARITY_SEARCH -- requirements
Module: sad_disparity_search

---
 rtl/sad_disparity_search.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sad_disparity_search.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sad_disparity_search                                                       |
// | Block-matching disparity search: finds the minimum-SAD candidate window    |
// | among MAX_DISP candidates compared against one registered reference window.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sad_disparity_search #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int MAX_DISP  = 64,
  parameter int SAD_SIZE  = $clog2(WIN * WIN * ((1 << DATA_SIZE) - 1) + 1),
  parameter int DISP_W    = ($clog2(MAX_DISP) > 1) ? $clog2(MAX_DISP) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ref_valid,
  output logic                          ref_ready,
  input  logic [DATA_SIZE*WIN*WIN-1:0]  ref_win,
  input  logic                          cand_valid,
  output logic                          cand_ready,
  input  logic [DATA_SIZE*WIN*WIN-1:0]  cand_win,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DISP_W-1:0]             out_disp,
  output logic [SAD_SIZE-1:0]           out_sad
);

  localparam int NPIX = WIN * WIN;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [DATA_SIZE*NPIX-1:0]     r_ref;
  logic [DISP_W-1:0]             r_count;
  logic                          r_s1_valid;
  logic [SAD_SIZE-1:0]           r_s1_sad;
  logic [DISP_W-1:0]             r_s1_disp;
  logic [SAD_SIZE-1:0]           r_best_sad;
  logic [DISP_W-1:0]             r_best_disp;
  logic [DISP_W-1:0]             r_out_disp;
  logic [SAD_SIZE-1:0]           r_out_sad;
  logic [SAD_SIZE-1:0]           w_sad;
  logic [DATA_SIZE-1:0]          w_pr;
  logic [DATA_SIZE-1:0]          w_pc;
  logic                          w_ref_hs;
  logic                          w_cand_hs;
  logic                          w_last_cand;

  assign ref_ready   = (r_state == S_IDLE)   && !rst;
  assign cand_ready  = (r_state == S_SEARCH) && !rst;
  assign w_ref_hs    = ref_valid  && ref_ready;
  assign w_cand_hs   = cand_valid && cand_ready;
  assign w_last_cand = (r_count == DISP_W'(MAX_DISP - 1));
  assign out_valid   = (r_state == S_DONE);
  assign out_disp    = r_out_disp;
  assign out_sad     = r_out_sad;

  // Full-width absolute-difference adder tree; each term is widened before summing.
  always_comb begin
    w_sad = '0;
    w_pr  = '0;
    w_pc  = '0;
    for (int p = 0; p < NPIX; p++) begin
      w_pr  = r_ref[DATA_SIZE*p +: DATA_SIZE];
      w_pc  = cand_win[DATA_SIZE*p +: DATA_SIZE];
      w_sad = w_sad + SAD_SIZE'((w_pr > w_pc) ? (w_pr - w_pc) : (w_pc - w_pr));
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (ref_valid)                  w_state_next = S_SEARCH;
      S_SEARCH: if (cand_valid && w_last_cand)  w_state_next = S_DRAIN;
      S_DRAIN:  if (!r_s1_valid)                w_state_next = S_DONE;
      S_DONE:   if (out_ready)                  w_state_next = S_IDLE;
      default:                                  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ref       <= '0;
      r_count     <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_sad    <= '0;
      r_s1_disp   <= '0;
      r_best_sad  <= '0;
      r_best_disp <= '0;
      r_out_disp  <= '0;
      r_out_sad   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_s1_valid <= w_cand_hs;
      if (w_cand_hs) begin
        r_s1_sad  <= w_sad;
        r_s1_disp <= r_count;
        r_count   <= r_count + DISP_W'(1);
      end
      if (w_ref_hs) begin
        r_ref       <= ref_win;
        r_count     <= '0;
        r_best_sad  <= '1;
        r_best_disp <= '0;
      end else if (r_s1_valid && (r_s1_sad < r_best_sad)) begin
        // Strictly-less keeps the earliest index on ties.
        r_best_sad  <= r_s1_sad;
        r_best_disp <= r_s1_disp;
      end
      if ((r_state == S_DRAIN) && !r_s1_valid) begin
        r_out_disp <= r_best_disp;
        r_out_sad  <= r_best_sad;
      end
    end
  end

endmodule
`default_nettype wire
